ripple_adder_8bit: RTL and testbench

8-bit unsigned/two's-complement adder built from a chain of eight 1-bit full adders, with a registered result stage. Used wherever the datapath needs a small, area-cheap add with carry-in and carry-out; the ripple chain is combinational and the result is captured on the clock edge behind a simple valid qualifier.

---
 rtl/ripple_adder_8bit_pkg.sv | 14 +
 rtl/ripple_adder_8bit_full_adder.sv | 16 +
 rtl/ripple_adder_8bit.sv | 75 +++++++
 tb/tb_ripple_adder_8bit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ripple_adder_8bit_pkg.sv
// Purpose: shared width constant and result record for the 8-bit ripple adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ripple_adder_8bit_pkg;

  localparam int ADD_W = 8;

  // Carry-out sits above the sum so the packed record reads as the 9-bit total.
  typedef struct packed {
    logic             carry;
    logic [ADD_W-1:0] sum;
  } add_result_t;

endpackage : ripple_adder_8bit_pkg

// File: rtl/ripple_adder_8bit_full_adder.sv
// Purpose: 1-bit full adder cell, one stage of the ripple chain.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b - addend bits; ci - carry in; s - sum bit; co - carry out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

// File: rtl/ripple_adder_8bit.sv
// Purpose: 8-bit ripple-carry adder with a registered result stage and valid flag.
// Latency: 1 cycle from in_valid to out_valid.
// Backpressure: none; every in_valid cycle yields one out_valid cycle.
// Ports: clk, rst (async, active-high); A, B, cin, in_valid in;
//        sum, carry, out_valid out; ovf out only when RIPPLE_ADDER_OVF_EN is defined.
module ripple_adder_8bit
  import ripple_adder_8bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ADD_W-1:0] A,
  input  logic [ADD_W-1:0] B,
  input  logic             cin,
  input  logic             in_valid,
  output logic [ADD_W-1:0] sum,
  output logic             carry,
`ifdef RIPPLE_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  // Carry thread through the chain: w_c[0] is cin, w_c[ADD_W] is the carry out.
  logic [ADD_W:0]   w_c;
  logic [ADD_W-1:0] w_s;

  add_result_t r_res;
  logic        r_vld;

  assign w_c[0] = cin;

  for (genvar i = 0; i < ADD_W; i++) begin : g_fa
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

  // Result only moves on a valid cycle; the valid flag itself tracks every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_res.carry <= w_c[ADD_W];
        r_res.sum   <= w_s;
      end
    end
  end

`ifdef RIPPLE_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_c[ADD_W-1] ^ w_c[ADD_W];
    end
  end

  assign ovf = r_ovf;
`endif

  assign sum       = r_res.sum;
  assign carry     = r_res.carry;
  assign out_valid = r_vld;

endmodule : ripple_adder_8bit

// File: tb/tb_ripple_adder_8bit.sv
// Purpose: self-checking bench for ripple_adder_8bit (directed table, corner sequences, random).
// Latency: checks results 1 cycle after each valid input.
// Backpressure: none exercised (design has none).
module tb_ripple_adder_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       cin;
  logic       in_valid;
  logic [7:0] sum;
  logic       carry;
  logic       out_valid;
`ifdef RIPPLE_ADDER_OVF_EN
  logic       ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ripple_adder_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
`ifdef RIPPLE_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int ci;
    int exp_sum;
    int exp_carry;
    int exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // 4-state aware check of all outputs against expected values.
  task automatic chk_out(input string nm, input int es, input int ec, input int eo, input int ev);
    chk({nm, ".x"}, int'($isunknown({sum, carry, out_valid})), 0);
    chk({nm, ".sum"}, int'(sum), es);
    chk({nm, ".carry"}, int'(carry), ec);
    chk({nm, ".out_valid"}, int'(out_valid), ev);
`ifdef RIPPLE_ADDER_OVF_EN
    chk({nm, ".ovf"}, int'(ovf), eo);
`else
    if (eo < 0) $display("note: unexpected ovf expectation in %s", nm);
`endif
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void ref_add(input int a, input int b, input int ci,
                                  output int s, output int c, output int o);
    int tot;
    int sa;
    int sb;
    int st;
    tot = a + b + ci;
    s   = tot % 256;
    c   = tot / 256;
    sa  = (a > 127) ? a - 256 : a;
    sb  = (b > 127) ? b - 256 : b;
    st  = sa + sb + ci;
    o   = (st > 127 || st < -128) ? 1 : 0;
  endfunction

  task automatic drive(input int a, input int b, input int ci, input logic v);
    A        = 8'(a);
    B        = 8'(b);
    cin      = ci[0];
    in_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int m_sum, m_carry, m_ovf, m_vld;

  initial begin
    vecs[0] = '{5,   9,   0, 14,  0, 0};
    vecs[1] = '{111, 41,  0, 152, 0, 1};
    vecs[2] = '{15,  9,   0, 24,  0, 0};
    vecs[3] = '{2,   3,   0, 5,   0, 0};
    vecs[4] = '{255, 1,   0, 0,   1, 0};
    vecs[5] = '{255, 255, 1, 255, 1, 0};
    vecs[6] = '{128, 128, 0, 0,   1, 1};
    vecs[7] = '{127, 0,   1, 128, 0, 1};
    vecs[8] = '{0,   0,   0, 0,   0, 0};

    rst = 1'b1;
    drive(0, 0, 0, 1'b0);
    #2;
    chk_out("reset", 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;

    // Back-to-back table: out_valid must stay high every cycle.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b1);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_carry,
              vecs[i].exp_ovf, 1);
    end

    // Capture 111+41 then hold with in_valid low and changing inputs.
    drive(111, 41, 0, 1'b1);
    step();
    chk_out("pre_hold", 152, 0, 1, 1);
    drive(255, 255, 1, 1'b0);
    step();
    chk_out("hold1", 152, 0, 1, 0);
    drive(1, 2, 0, 1'b0);
    step();
    chk_out("hold2", 152, 0, 1, 0);

    // Async reset between edges while a result is presented.
    drive(200, 100, 1, 1'b1);
    step();
    chk_out("pre_rst", 45, 1, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    // Reset dominates a valid input across an edge.
    step();
    chk_out("rst_wins", 0, 0, 0, 0);
    #3;
    rst = 1'b0;
    drive(100, 50, 1, 1'b1);
    step();
    chk_out("post_rst", 151, 0, 1, 1);

    // Random traffic with sparse valids against the reference model.
    m_sum = 151; m_carry = 0; m_ovf = 1; m_vld = 1;
    for (int k = 0; k < 300; k++) begin
      int a, b, ci, s, c, o;
      logic v;
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      ci = int'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      drive(a, b, ci, v);
      step();
      if (v) begin
        ref_add(a, b, ci, s, c, o);
        m_sum = s; m_carry = c; m_ovf = o;
      end
      m_vld = v ? 1 : 0;
      chk_out($sformatf("rnd%0d", k), m_sum, m_carry, m_ovf, m_vld);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ripple_adder_8bit
